// File: rtl/lsu_pkg.sv
// -----------------------------------------------------------------------------
// lsu_pkg
// Shared definitions for the load/store unit controller:
//   - LSU_MEM_BYTES : default size of the data memory in bytes
//   - lsu_size_e    : access size encodings driven on the size port
//   - lsu_state_e   : controller FSM states
// -----------------------------------------------------------------------------
package lsu_pkg;

   // Default data-memory size; the highest legal word base is this minus 4.
   localparam int unsigned LSU_MEM_BYTES = 12288;

   // Access size encodings.
   typedef enum logic [1:0] {
      SZ_BYTE = 2'b00,
      SZ_HALF = 2'b01,
      SZ_WORD = 2'b10,
      SZ_ILL  = 2'b11
   } lsu_size_e;

   // Controller states.
   typedef enum logic [2:0] {
      IDLE = 3'd0,
      RD   = 3'd1,
      CAP  = 3'd2,
      WR   = 3'd3,
      FIN  = 3'd4
   } lsu_state_e;

endpackage : lsu_pkg

// File: rtl/lsu_lane.sv
// -----------------------------------------------------------------------------
// lsu_lane
// Combinational lane logic for the load/store unit.
//   word_i   : 32-bit little-endian word read from memory
//   wdata_i  : right-justified store data
//   size_i   : access size (lsu_size_e encoding)
//   off_i    : effective byte offset inside the word (already aligned to size)
//   sext_i   : 1 = sign-extend sub-word loads, 0 = zero-extend
//   merged_o : word_i with the addressed lanes replaced by store data
//   load_o   : addressed lanes of word_i, right-justified and extended
// -----------------------------------------------------------------------------
module lsu_lane
   import lsu_pkg::*;
(
   input  logic [31:0] word_i,
   input  logic [31:0] wdata_i,
   input  logic [1:0]  size_i,
   input  logic [1:0]  off_i,
   input  logic        sext_i,
   output logic [31:0] merged_o,
   output logic [31:0] load_o
);

   logic [31:0] shifted_s;

   // Store merge: replace only the addressed byte or halfword lanes.
   always_comb begin
      merged_o = word_i;
      case (size_i)
         SZ_BYTE: begin
            case (off_i)
               2'b00:   merged_o[7:0]   = wdata_i[7:0];
               2'b01:   merged_o[15:8]  = wdata_i[7:0];
               2'b10:   merged_o[23:16] = wdata_i[7:0];
               default: merged_o[31:24] = wdata_i[7:0];
            endcase
         end
         SZ_HALF: begin
            if (off_i[1]) begin
               merged_o[31:16] = wdata_i[15:0];
            end else begin
               merged_o[15:0]  = wdata_i[15:0];
            end
         end
         SZ_WORD: merged_o = wdata_i;
         default: merged_o = word_i;
      endcase
   end

   // Load extract: shift the addressed lane down to bit 0, then extend.
   always_comb begin
      shifted_s = word_i >> {off_i, 3'b000};
      load_o    = 32'h0000_0000;
      case (size_i)
         SZ_BYTE: load_o = {{24{sext_i & shifted_s[7]}},  shifted_s[7:0]};
         SZ_HALF: load_o = {{16{sext_i & shifted_s[15]}}, shifted_s[15:0]};
         // Word offset is always zero, so the shift is a pass-through here.
         SZ_WORD: load_o = shifted_s;
         default: load_o = 32'h0000_0000;
      endcase
   end

endmodule : lsu_lane

// File: rtl/lsu_ctrl.sv
// -----------------------------------------------------------------------------
// lsu_ctrl
// Load/store unit controller between a core-side request port and a
// single-port synchronous data memory. Sub-word stores are done as
// read-modify-write; loads are extracted and extended in lsu_lane.
//
// Configuration macro: LSU_MISALIGN_TRAP_EN
//   defined   : misaligned half/word accesses complete with err=1
//   undefined : offending low address bits are ignored (treated as 0)
//
// Ports
//   clk, rst        : clock, synchronous active-high reset
//   req, wr, size,
//   sext, addr,
//   wdata           : request (accepted only while ready=1)
//   ready           : controller idle
//   done, err       : one-cycle completion pulse, abort flag valid with done
//   rdata           : load result, held until the next load completes
//   mem_addr        : word-aligned memory address
//   mem_din, mem_we : memory write data / write enable
//   mem_dout        : memory read data, valid one cycle after mem_addr
// -----------------------------------------------------------------------------
module lsu_ctrl
   import lsu_pkg::*;
#(
   parameter int ADDR_W    = 14,
   parameter int MEM_BYTES = LSU_MEM_BYTES
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req,
   input  logic              wr,
   input  logic [1:0]        size,
   input  logic              sext,
   input  logic [ADDR_W-1:0] addr,
   input  logic [31:0]       wdata,
   output logic              ready,
   output logic              done,
   output logic              err,
   output logic [31:0]       rdata,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_din,
   output logic              mem_we,
   input  logic [31:0]       mem_dout
);

   localparam logic [ADDR_W-1:0] LAST_BASE = ADDR_W'(MEM_BYTES - 4);

   lsu_state_e        state_q, state_d;
   logic              wr_q, wr_d;
   logic [1:0]        size_q, size_d;
   logic              sext_q, sext_d;
   logic [1:0]        off_q, off_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [31:0]       mem_din_q, mem_din_d;
   logic [31:0]       rdata_q, rdata_d;
   logic              ready_q, ready_d;
   logic              done_q, done_d;
   logic              err_q, err_d;
   logic              mem_we_q, mem_we_d;

   logic [ADDR_W-1:0] base_s;
   logic [1:0]        off_s;
   logic              trap_s;
   logic              illegal_s;
   logic [31:0]       merged_s;
   logic [31:0]       load_s;

   lsu_lane u_lane (
      .word_i   (mem_dout),
      .wdata_i  (wdata_q),
      .size_i   (size_q),
      .off_i    (off_q),
      .sext_i   (sext_q),
      .merged_o (merged_s),
      .load_o   (load_s)
   );

`ifdef LSU_MISALIGN_TRAP_EN
   assign trap_s = ((size == SZ_HALF) && addr[0]) ||
                   ((size == SZ_WORD) && (addr[1:0] != 2'b00));
`else
   assign trap_s = 1'b0;
`endif

   // Request decode: word base, size-aligned lane offset and legality.
   always_comb begin
      base_s = {addr[ADDR_W-1:2], 2'b00};
      case (size)
         SZ_BYTE: off_s = addr[1:0];
         SZ_HALF: off_s = {addr[1], 1'b0};
         SZ_WORD: off_s = 2'b00;
         default: off_s = 2'b00;
      endcase
      illegal_s = (size == SZ_ILL) || (base_s > LAST_BASE) || trap_s;
   end

   // Next-state and next-register logic; outputs follow the next state so
   // they are all registered.
   always_comb begin
      state_d    = state_q;
      wr_d       = wr_q;
      size_d     = size_q;
      sext_d     = sext_q;
      off_d      = off_q;
      wdata_d    = wdata_q;
      mem_addr_d = mem_addr_q;
      mem_din_d  = mem_din_q;
      rdata_d    = rdata_q;
      err_d      = 1'b0;
      case (state_q)
         IDLE: begin
            if (req) begin
               wr_d    = wr;
               size_d  = size;
               sext_d  = sext;
               off_d   = off_s;
               wdata_d = wdata;
               if (illegal_s) begin
                  // Aborted access never touches memory or rdata.
                  state_d = FIN;
                  err_d   = 1'b1;
               end else if (wr && (size == SZ_WORD)) begin
                  state_d    = WR;
                  mem_addr_d = base_s;
                  mem_din_d  = wdata;
               end else begin
                  state_d    = RD;
                  mem_addr_d = base_s;
               end
            end else begin
               state_d = IDLE;
            end
         end
         RD:  state_d = CAP;
         CAP: begin
            // mem_dout is valid in this cycle; fold it into the write word
            // or the load result as it is captured.
            if (wr_q) begin
               state_d   = WR;
               mem_din_d = merged_s;
            end else begin
               state_d = FIN;
               rdata_d = load_s;
            end
         end
         WR:      state_d = FIN;
         FIN:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
      ready_d  = (state_d == IDLE);
      done_d   = (state_d == FIN);
      mem_we_d = (state_d == WR);
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         wr_q       <= 1'b0;
         size_q     <= 2'b00;
         sext_q     <= 1'b0;
         off_q      <= 2'b00;
         wdata_q    <= 32'h0000_0000;
         mem_addr_q <= '0;
         mem_din_q  <= 32'h0000_0000;
         rdata_q    <= 32'h0000_0000;
         ready_q    <= 1'b1;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         mem_we_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         wr_q       <= wr_d;
         size_q     <= size_d;
         sext_q     <= sext_d;
         off_q      <= off_d;
         wdata_q    <= wdata_d;
         mem_addr_q <= mem_addr_d;
         mem_din_q  <= mem_din_d;
         rdata_q    <= rdata_d;
         ready_q    <= ready_d;
         done_q     <= done_d;
         err_q      <= err_d;
         mem_we_q   <= mem_we_d;
      end
   end

   assign ready    = ready_q;
   assign done     = done_q;
   assign err      = err_q;
   assign rdata    = rdata_q;
   assign mem_addr = mem_addr_q;
   assign mem_din  = mem_din_q;
   assign mem_we   = mem_we_q;

endmodule : lsu_ctrl

// File: tb/tb_lsu_ctrl.sv
// -----------------------------------------------------------------------------
// tb_lsu_ctrl
// Directed bench for lsu_ctrl with a behavioural synchronous memory and a
// scoreboard of expected completions (latency, err, rdata).
// -----------------------------------------------------------------------------
module tb_lsu_ctrl;

   typedef struct packed {
      logic        err;
      logic        chk_rd;
      logic [31:0] rd;
      logic [31:0] lat;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst, req, wr, sext;
   logic [1:0]  size;
   logic [13:0] addr, mem_addr;
   logic [31:0] wdata, rdata, mem_din, mem_dout;
   logic        ready, done, err, mem_we;

   logic [31:0] mem [0:4095];
   int          total = 0;
   int          bad   = 0;
   int          we_cnt = 0;
   exp_t        sb[$];
   string       tag_q[$];

   always #5 clk = ~clk;

   lsu_ctrl dut (
      .clk      (clk),
      .rst      (rst),
      .req      (req),
      .wr       (wr),
      .size     (size),
      .sext     (sext),
      .addr     (addr),
      .wdata    (wdata),
      .ready    (ready),
      .done     (done),
      .err      (err),
      .rdata    (rdata),
      .mem_addr (mem_addr),
      .mem_din  (mem_din),
      .mem_we   (mem_we),
      .mem_dout (mem_dout)
   );

   // Synchronous data memory, one-cycle read latency, plus write counter.
   always @(posedge clk) begin
      if (mem_we) begin
         mem[mem_addr[13:2]] <= mem_din;
         we_cnt <= we_cnt + 1;
      end
      mem_dout <= mem[mem_addr[13:2]];
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Drive one request, push its expected completion, return after acceptance.
   task automatic send(input string tag, input logic w, input logic [1:0] sz,
                       input logic sx, input logic [13:0] a, input logic [31:0] d,
                       input logic e_err, input logic e_chk, input logic [31:0] e_rd,
                       input int e_lat);
      exp_t e;
      @(negedge clk);
      check({tag, "_ready"}, 32'(ready), 32'd1);
      req = 1'b1; wr = w; size = sz; sext = sx; addr = a; wdata = d;
      e.err = e_err; e.chk_rd = e_chk; e.rd = e_rd; e.lat = 32'(e_lat);
      sb.push_back(e);
      tag_q.push_back(tag);
      @(posedge clk);
      #1 req = 1'b0;
   endtask

   // Wait (bounded) for done, pop the scoreboard and compare.
   task automatic wait_done(input int n0);
      int    n;
      logic  seen;
      exp_t  e;
      string t;
      n = n0;
      seen = 1'b0;
      while (!seen && n < 16) begin
         @(negedge clk);
         n++;
         if (done === 1'b1) seen = 1'b1;
      end
      t = tag_q.pop_front();
      e = sb.pop_front();
      check({t, "_lat"}, 32'(n), e.lat);
      check({t, "_err"}, 32'(err), 32'(e.err));
      if (e.chk_rd) check({t, "_rdata"}, rdata, e.rd);
   endtask

   initial begin
      int   w0;
      logic seen;

      rst = 1'b1; req = 1'b0; wr = 1'b0; size = 2'b00; sext = 1'b0;
      addr = 14'h0000; wdata = 32'h0000_0000;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_ready",    32'(ready),    32'd1);
      check("rst_done",     32'(done),     32'd0);
      check("rst_err",      32'(err),      32'd0);
      check("rst_mem_we",   32'(mem_we),   32'd0);
      check("rst_rdata",    rdata,         32'h0000_0000);
      check("rst_mem_addr", 32'(mem_addr), 32'd0);
      rst = 1'b0;

      // Word store then word load.
      w0 = we_cnt;
      send("wst", 1'b1, 2'b10, 1'b0, 14'h010, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0, 2);
      wait_done(0);
      check("wst_mem", mem[4], 32'hDEADBEEF);
      check("wst_we_cnt", 32'(we_cnt - w0), 32'd1);
      @(negedge clk);
      check("wst_pulse", 32'(done), 32'd0);
      send("wld", 1'b0, 2'b10, 1'b0, 14'h010, 32'h0, 1'b0, 1'b1, 32'hDEADBEEF, 3);
      wait_done(0);

      // Byte merge.
      send("pre20", 1'b1, 2'b10, 1'b0, 14'h020, 32'h11223344, 1'b0, 1'b0, 32'h0, 2);
      wait_done(0);
      w0 = we_cnt;
      send("stb", 1'b1, 2'b00, 1'b0, 14'h022, 32'h000000AA, 1'b0, 1'b0, 32'h0, 4);
      wait_done(0);
      check("stb_mem", mem[8], 32'h11AA3344);
      check("stb_we_cnt", 32'(we_cnt - w0), 32'd1);

      // Extension.
      send("pre30", 1'b1, 2'b10, 1'b0, 14'h030, 32'h0000F080, 1'b0, 1'b0, 32'h0, 2);
      wait_done(0);
      send("lbs",  1'b0, 2'b00, 1'b1, 14'h030, 32'h0, 1'b0, 1'b1, 32'hFFFFFF80, 3);
      wait_done(0);
      send("lbz",  1'b0, 2'b00, 1'b0, 14'h030, 32'h0, 1'b0, 1'b1, 32'h00000080, 3);
      wait_done(0);
      send("lhs",  1'b0, 2'b01, 1'b1, 14'h030, 32'h0, 1'b0, 1'b1, 32'hFFFFF080, 3);
      wait_done(0);
      send("lb1s", 1'b0, 2'b00, 1'b1, 14'h031, 32'h0, 1'b0, 1'b1, 32'hFFFFFFF0, 3);
      wait_done(0);
      send("lhhi", 1'b0, 2'b01, 1'b1, 14'h032, 32'h0, 1'b0, 1'b1, 32'h00000000, 3);
      wait_done(0);

      // Boundary and illegal accesses.
      send("pre2ffc", 1'b1, 2'b10, 1'b0, 14'h2FFC, 32'h5A5A1234, 1'b0, 1'b0, 32'h0, 2);
      wait_done(0);
      send("lw2ffc", 1'b0, 2'b10, 1'b0, 14'h2FFC, 32'h0, 1'b0, 1'b1, 32'h5A5A1234, 3);
      wait_done(0);
      w0 = we_cnt;
      send("lw3000", 1'b0, 2'b10, 1'b0, 14'h3000, 32'h0, 1'b1, 1'b1, 32'h5A5A1234, 1);
      wait_done(0);
      send("sz11ld", 1'b0, 2'b11, 1'b0, 14'h050, 32'h0, 1'b1, 1'b1, 32'h5A5A1234, 1);
      wait_done(0);
      send("sz11st", 1'b1, 2'b11, 1'b0, 14'h050, 32'h1, 1'b1, 1'b1, 32'h5A5A1234, 1);
      wait_done(0);
      check("ill_we_cnt", 32'(we_cnt - w0), 32'd0);

      // Misaligned halfword store.
      send("pre40", 1'b1, 2'b10, 1'b0, 14'h040, 32'h12345678, 1'b0, 1'b0, 32'h0, 2);
      wait_done(0);
      w0 = we_cnt;
`ifdef LSU_MISALIGN_TRAP_EN
      send("mis", 1'b1, 2'b01, 1'b0, 14'h041, 32'h0000BEEF, 1'b1, 1'b1, 32'h5A5A1234, 1);
      wait_done(0);
      check("mis_mem", mem[16], 32'h12345678);
      check("mis_we_cnt", 32'(we_cnt - w0), 32'd0);
`else
      send("mis", 1'b1, 2'b01, 1'b0, 14'h041, 32'h0000BEEF, 1'b0, 1'b1, 32'h5A5A1234, 4);
      wait_done(0);
      check("mis_mem", mem[16], 32'h1234BEEF);
      check("mis_we_cnt", 32'(we_cnt - w0), 32'd1);
`endif

      // Reset asserted while in WR of a sub-word store.
      @(negedge clk);
      req = 1'b1; wr = 1'b1; size = 2'b00; sext = 1'b0; addr = 14'h061; wdata = 32'h77;
      @(posedge clk);
      #1 req = 1'b0;
      repeat (3) @(negedge clk);
      check("rwr_we_on", 32'(mem_we), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      check("rwr_we_off", 32'(mem_we), 32'd0);
      check("rwr_done",   32'(done),   32'd0);
      check("rwr_ready",  32'(ready),  32'd1);
      check("rwr_rdata",  rdata,       32'h0000_0000);
      rst = 1'b0;
      seen = 1'b0;
      repeat (6) begin
         @(negedge clk);
         if (done === 1'b1) seen = 1'b1;
      end
      check("rwr_nodone", 32'(seen), 32'd0);

      // Request pulsed while busy is ignored.
      w0 = we_cnt;
      send("busy", 1'b0, 2'b10, 1'b0, 14'h010, 32'h0, 1'b0, 1'b1, 32'hDEADBEEF, 3);
      check("busy_ready", 32'(ready), 32'd0);
      req = 1'b1; wr = 1'b1; size = 2'b10; addr = 14'h010; wdata = 32'h0BADF00D;
      @(negedge clk);
      req = 1'b0;
      wait_done(1);
      seen = 1'b0;
      repeat (8) begin
         @(negedge clk);
         if (done === 1'b1) seen = 1'b1;
      end
      check("busy_nodone", 32'(seen), 32'd0);
      check("busy_we_cnt", 32'(we_cnt - w0), 32'd0);
      check("busy_mem", mem[4], 32'hDEADBEEF);
      check("sb_empty", 32'(sb.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_lsu_ctrl

// File: doc/lsu_ctrl.md
LSU_CTRL -- requirements
Module: lsu_ctrl

Interface
REQ-001 Parameter: ADDR_W, 14, byte-address width of the data-memory port.
REQ-002 Parameter: MEM_BYTES, 12288, number of addressable bytes; the highest legal word base is MEM_BYTES-4.
REQ-003 Port: clk  in  1  single clock; all state updates on rising edge.
REQ-004 Port: rst  in  1  synchronous, active-high reset.
REQ-005 Port: req  in  1  access request; sampled only while ready=1.
REQ-006 Port: wr  in  1  1=store, 0=load; sampled with req.
REQ-007 Port: size  in  2  00=byte, 01=half, 10=word, 11=illegal.
REQ-008 Port: sext  in  1  sign-extend sub-word loads when 1, zero-extend when 0.
REQ-009 Port: addr  in  ADDR_W  byte address.
REQ-010 Port: wdata  in  32  store data, right-justified.
REQ-011 Port: ready  out  1  high only in IDLE.
REQ-012 Port: done  out  1  one-cycle completion pulse.
REQ-013 Port: err  out  1  valid with done; access aborted.
REQ-014 Port: rdata  out  32  load result; held until next done.
REQ-015 Port: mem_addr  out  ADDR_W  word-aligned address to data memory (addr[1:0] forced to 00).
REQ-016 Port: mem_din  out  32  write word to data memory.
REQ-017 Port: mem_we  out  1  memory write enable.
REQ-018 Port: mem_dout  in  32  little-endian read word, valid the cycle after mem_addr is presented with mem_we=0.

Function
REQ-019 The FSM SHALL use the states IDLE, RD, CAP, WR and FIN.
REQ-020 In IDLE with req=1, addr, wr, size, sext and wdata SHALL be registered. The next state SHALL be:
- FIN with err=1 for an illegal access;
- WR for a word store;
- RD for everything else.
REQ-021 RD SHALL drive mem_addr and hold mem_we=0; the next state SHALL be CAP.
REQ-022 CAP SHALL register mem_dout. The next state SHALL be WR for a sub-word store and FIN for a load.
REQ-023 WR SHALL assert mem_we for exactly one cycle. mem_din SHALL be the captured word with only the addressed byte or halfword lanes replaced by wdata[7:0] or wdata[15:0]; a word store SHALL drive wdata unchanged. The next state SHALL be FIN.
REQ-024 FIN SHALL assert done for one cycle. A load SHALL update rdata with the extracted lane, extended per sext. The next state SHALL be IDLE.
REQ-025 Latency from the accepting edge to done:
- load: 3 cycles;
- word store: 2 cycles;
- sub-word store: 4 cycles;
- illegal access: 1 cycle.
REQ-026 An access SHALL be illegal if size=11 or if aligned addr > MEM_BYTES-4. An illegal access SHALL produce no mem_we and SHALL leave rdata unchanged.
REQ-027 A req arriving while ready=0 SHALL be ignored; no queuing.
REQ-028 mem_we SHALL be 0 in every state except WR.
REQ-029 Lane selection SHALL use the addr[1:0] byte offset, little-endian. A half access SHALL use addr[1] only.

Reset
REQ-030 On rst the FSM SHALL enter IDLE, with ready=1, done=0, err=0, mem_we=0, rdata=0 and mem_addr=0, from the next edge.
REQ-031 A reset asserted mid-access SHALL abort it with no done pulse. A reset asserted in WR SHALL cause mem_we to fall at that edge.

Configuration
REQ-032 Macro LSU_MISALIGN_TRAP_EN selects the misalignment behaviour.
- Defined: a half access with addr[0]=1, or a word access with addr[1:0]!=00, SHALL be illegal (REQ-026).
- Undefined: the offending low address bits SHALL be treated as 0 and the access SHALL proceed normally.

Structure
REQ-033 Package lsu_pkg SHALL hold the size encodings, the state enumeration and the MEM_BYTES default.
REQ-034 Sub-module lsu_lane (combinational) SHALL perform the store merge and the load extract/extend; lsu_ctrl SHALL hold the FSM and registers only.

Verification
REQ-035 Word store then word load: store 0xDEADBEEF @0x010, load word @0x010 -> rdata=0xDEADBEEF; done 2 cycles after the store is accepted and 3 cycles after the load is accepted.
REQ-036 Byte merge: memory @0x020=0x11223344; store byte 0xAA @0x022 -> word @0x020 becomes 0x11AA3344; one mem_we cycle only.
REQ-037 Extension: memory @0x030=0x0000F080; load byte @0x030 with sext=1 -> 0xFFFFFF80; with sext=0 -> 0x00000080; load half @0x030 with sext=1 -> 0xFFFFF080.
REQ-038 Illegal access:
- load word @0x2FFC -> err=0, completes;
- load word @0x3000 -> done and err in 1 cycle, no memory access;
- size=11 -> err=1.
REQ-039 Misalignment: store half @0x041 -> with LSU_MISALIGN_TRAP_EN, err=1 and memory unchanged; without it, the halfword is written at 0x040.
REQ-040 Reset/busy: assert rst during WR -> mem_we=0 and no done. A req pulsed during RD -> ignored, and no second access occurs.
